// File: rtl/pipe_issue_ctrl.sv
// Decode-to-EX issue controller: RAW scoreboard, serialising FSM for CSR/system ops, redirect flush.
// Optional `PIPE_ISSUE_WB_BYPASS_EN lets a source that retires this cycle skip its hazard.
module pipe_issue_ctrl #(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic       id_rs1_ren_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_rs2_ren_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_rd_wen_i,
   input  logic       id_serial_i,
   input  logic       ex_ready_i,
   input  logic       wb_valid_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_wen_i,
   input  logic       serial_done_i,
   input  logic       redirect_i,
   output logic       issue_fire_o,
   output logic       id_stall_o,
   output logic       flush_o,
   output logic [3:0] inflight_o,
   output logic       serial_busy_o
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SERIAL} state_e;

   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [3:0]       INFL_MAX = 4'(MAX_INFLIGHT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];
   logic [3:0]       infl_q, infl_d;

   logic        wb_ret;
   logic        rs1_haz, rs2_haz, hazard;
   logic        full, rd_sat, can_issue, fire;
   logic [31:0] inc_v, dec_v;

   assign wb_ret = wb_valid_i && wb_wen_i && (wb_rd_i != 5'd0);

   always_comb begin
      rs1_haz = id_rs1_ren_i && (id_rs1_i != 5'd0) && (cnt_q[id_rs1_i] != '0);
      rs2_haz = id_rs2_ren_i && (id_rs2_i != 5'd0) && (cnt_q[id_rs2_i] != '0);
`ifdef PIPE_ISSUE_WB_BYPASS_EN
      // The last pending write lands this cycle; the register file forwards it.
      if (wb_ret && (wb_rd_i == id_rs1_i) && (cnt_q[id_rs1_i] == CNT_ONE)) rs1_haz = 1'b0;
      if (wb_ret && (wb_rd_i == id_rs2_i) && (cnt_q[id_rs2_i] == CNT_ONE)) rs2_haz = 1'b0;
`endif
   end

   assign hazard    = rs1_haz || rs2_haz;
   assign full      = (infl_q == INFL_MAX);
   assign rd_sat    = id_rd_wen_i && (id_rd_i != 5'd0) && (cnt_q[id_rd_i] == CNT_SAT);
   assign can_issue = id_valid_i && ex_ready_i && !redirect_i && !hazard && !full && !rd_sat;

   always_comb begin
      state_d = state_q;
      fire    = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (id_serial_i && (infl_q != 4'd0)) begin
               if (id_valid_i && !redirect_i) state_d = S_DRAIN;
            end else begin
               fire = can_issue;
               if (can_issue && id_serial_i) state_d = S_SERIAL;
            end
         end
         S_DRAIN: begin
            if (redirect_i || !id_valid_i) begin
               state_d = S_RUN;
            end else if (infl_q == 4'd0) begin
               fire = can_issue;
               if (can_issue) state_d = S_SERIAL;
            end
         end
         S_SERIAL: begin
            if (serial_done_i) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   // A same-cycle issue and retire on one register cancel; a retire never underflows.
   always_comb begin
      inc_v = '0;
      dec_v = '0;
      if (fire && id_rd_wen_i && (id_rd_i != 5'd0)) inc_v[id_rd_i] = 1'b1;
      if (wb_ret && ((cnt_q[wb_rd_i] != '0) || inc_v[wb_rd_i])) dec_v[wb_rd_i] = 1'b1;
      for (int i = 0; i < 32; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_v[i] && !dec_v[i]) cnt_d[i] = cnt_q[i] + CNT_ONE;
         else if (dec_v[i] && !inc_v[i]) cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
   end

   always_comb begin
      infl_d = infl_q;
      if (fire && !wb_valid_i) infl_d = infl_q + 4'd1;
      else if (wb_valid_i && !fire && (infl_q != 4'd0)) infl_d = infl_q - 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_RUN;
         infl_q  <= 4'd0;
         for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         infl_q  <= infl_d;
         for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign issue_fire_o  = fire;
   assign id_stall_o    = id_valid_i && !fire;
   assign flush_o       = redirect_i;
   assign inflight_o    = infl_q;
   assign serial_busy_o = (state_q != S_RUN);

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural scoreboard model.
module tb_pipe_issue_ctrl;

   localparam int MAXI   = 4;
   localparam int CNTW   = 2;
   localparam int CNTSAT = (1 << CNTW) - 1;
   localparam int M_RUN = 0, M_DRAIN = 1, M_SERIAL = 2;

   logic       clk_i = 1'b0;
   logic       rst_i, id_valid_i, id_rs1_ren_i, id_rs2_ren_i, id_rd_wen_i, id_serial_i;
   logic [4:0] id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
   logic       ex_ready_i, wb_valid_i, wb_wen_i, serial_done_i, redirect_i;
   logic       issue_fire_o, id_stall_o, flush_o, serial_busy_o;
   logic [3:0] inflight_o;

   pipe_issue_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(CNTW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs1_ren_i(id_rs1_ren_i),
      .id_rs2_i(id_rs2_i), .id_rs2_ren_i(id_rs2_ren_i),
      .id_rd_i(id_rd_i), .id_rd_wen_i(id_rd_wen_i), .id_serial_i(id_serial_i),
      .ex_ready_i(ex_ready_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
      .wb_wen_i(wb_wen_i), .serial_done_i(serial_done_i), .redirect_i(redirect_i),
      .issue_fire_o(issue_fire_o), .id_stall_o(id_stall_o), .flush_o(flush_o),
      .inflight_o(inflight_o), .serial_busy_o(serial_busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {logic [4:0] rd; logic wen;} ins_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_cnt [32];
   int   m_infl;
   int   m_mode;
   bit   m_fire;
   ins_t pipe_q[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit pend(input int r);
      bit p;
      p = (r != 0) && (m_cnt[r] != 0);
`ifdef PIPE_ISSUE_WB_BYPASS_EN
      if (p && m_cnt[r] == 1 && wb_valid_i && wb_wen_i && int'(wb_rd_i) == r) p = 1'b0;
`endif
      return p;
   endfunction

   // Compare all outputs against the model at the falling edge, then advance the model.
   task automatic eval();
      bit haz, blocked, go, e_fire;
      int old_infl;
      @(negedge clk_i);
      if (rst_i) begin
         m_mode = M_RUN;
         m_infl = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         pipe_q.delete();
         m_fire = 1'b0;
         return;
      end
      haz     = (id_rs1_ren_i && pend(int'(id_rs1_i))) || (id_rs2_ren_i && pend(int'(id_rs2_i)));
      blocked = haz || (m_infl == MAXI) || (id_rd_wen_i && m_cnt[id_rd_i] == CNTSAT && id_rd_i != 0);
      go      = id_valid_i && ex_ready_i && !redirect_i && !blocked;
      case (m_mode)
         M_RUN:   e_fire = go && !(id_serial_i && m_infl != 0);
         M_DRAIN: e_fire = go && (m_infl == 0);
         default: e_fire = 1'b0;
      endcase
      chk("issue_fire", issue_fire_o, e_fire);
      chk("id_stall", id_stall_o, id_valid_i && !e_fire);
      chk("flush", flush_o, redirect_i);
      chk("inflight", inflight_o, m_infl);
      chk("serial_busy", serial_busy_o, m_mode != M_RUN);
      old_infl = m_infl;
      if (e_fire && id_rd_wen_i && id_rd_i != 0) m_cnt[id_rd_i]++;
      if (wb_valid_i && wb_wen_i && wb_rd_i != 0 && m_cnt[wb_rd_i] > 0) m_cnt[wb_rd_i]--;
      if (e_fire) m_infl++;
      if (wb_valid_i && m_infl > 0) m_infl--;
      case (m_mode)
         M_RUN: begin
            if (e_fire && id_serial_i) m_mode = M_SERIAL;
            else if (id_valid_i && id_serial_i && !redirect_i && old_infl != 0) m_mode = M_DRAIN;
         end
         M_DRAIN: begin
            if (redirect_i || !id_valid_i) m_mode = M_RUN;
            else if (e_fire) m_mode = M_SERIAL;
         end
         default: if (serial_done_i) m_mode = M_RUN;
      endcase
      if (e_fire) pipe_q.push_back('{rd: id_rd_i, wen: id_rd_wen_i});
      m_fire = e_fire;
   endtask

   task automatic adv();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_in();
      rst_i = 0; id_valid_i = 0; id_rs1_i = 0; id_rs1_ren_i = 0; id_rs2_i = 0; id_rs2_ren_i = 0;
      id_rd_i = 0; id_rd_wen_i = 0; id_serial_i = 0; ex_ready_i = 1; wb_valid_i = 0;
      wb_rd_i = 0; wb_wen_i = 0; serial_done_i = 0; redirect_i = 0;
   endtask

   task automatic set_id(input int rs1, input bit r1en, input int rs2, input bit r2en,
                         input int rd, input bit wen, input bit ser);
      id_valid_i = 1; id_rs1_i = 5'(rs1); id_rs1_ren_i = r1en; id_rs2_i = 5'(rs2);
      id_rs2_ren_i = r2en; id_rd_i = 5'(rd); id_rd_wen_i = wen; id_serial_i = ser;
   endtask

   task automatic wb_on();
      ins_t w;
      w = pipe_q.pop_front();
      wb_valid_i = 1; wb_rd_i = w.rd; wb_wen_i = w.wen;
   endtask

   task automatic wb_off();
      wb_valid_i = 0; wb_rd_i = 0; wb_wen_i = 0;
   endtask

   task automatic retire_all();
      id_valid_i = 0;
      while (pipe_q.size() > 0) begin
         wb_on(); eval(); adv(); wb_off();
      end
   endtask

   bit need_new;

   initial begin
      clear_in();
      // Reset: all outputs low the cycle after
      rst_i = 1; eval(); adv();
      rst_i = 0; eval();
      chk("rst_fire", issue_fire_o, 0); chk("rst_stall", id_stall_o, 0);
      chk("rst_flush", flush_o, 0); chk("rst_infl", inflight_o, 0); chk("rst_busy", serial_busy_o, 0);
      adv();

      // RAW on x5
      set_id(1, 0, 2, 0, 5, 1, 0); eval(); chk("raw_add_fire", issue_fire_o, 1); adv();
      set_id(5, 1, 0, 0, 6, 1, 0); eval(); chk("raw_dep_stall", id_stall_o, 1);
      chk("raw_infl", inflight_o, 1); adv();
      eval(); chk("raw_dep_stall2", id_stall_o, 1); adv();
      wb_on(); eval();
`ifdef PIPE_ISSUE_WB_BYPASS_EN
      chk("raw_wb_cycle_fire", issue_fire_o, 1); adv(); wb_off();
`else
      chk("raw_wb_cycle_fire", issue_fire_o, 0); adv(); wb_off();
      eval(); chk("raw_after_wb_fire", issue_fire_o, 1); adv();
`endif
      retire_all();

      // Inflight limit
      for (int i = 0; i < 4; i++) begin
         set_id(0, 0, 0, 0, 10 + i, 1, 0); eval(); chk("lim_fire", issue_fire_o, 1); adv();
      end
      set_id(0, 0, 0, 0, 14, 1, 0); eval(); chk("lim_5th_stall", id_stall_o, 1);
      chk("lim_infl4", inflight_o, 4); adv();
      wb_on(); eval(); chk("lim_wb_stall", id_stall_o, 1); adv(); wb_off();
      eval(); chk("lim_5th_fire", issue_fire_o, 1); chk("lim_infl3", inflight_o, 3); adv();
      id_valid_i = 0; eval(); chk("lim_infl_back4", inflight_o, 4); adv();
      retire_all();

      // Serialisation with drain
      set_id(0, 0, 0, 0, 20, 1, 0); eval(); adv();
      set_id(0, 0, 0, 0, 21, 1, 0); eval(); adv();
      set_id(1, 1, 0, 0, 22, 1, 1); eval(); chk("ser_stall", id_stall_o, 1); adv();
      eval(); chk("ser_drain_busy", serial_busy_o, 1); adv();
      wb_on(); eval(); adv(); wb_off();
      wb_on(); eval(); chk("ser_drain_stall", id_stall_o, 1); adv(); wb_off();
      eval(); chk("ser_fire", issue_fire_o, 1); adv();
      set_id(0, 0, 0, 0, 23, 1, 0); eval(); chk("ser_next_stall", id_stall_o, 1);
      chk("ser_busy", serial_busy_o, 1); adv();
      serial_done_i = 1; eval(); chk("ser_done_stall", id_stall_o, 1); adv(); serial_done_i = 0;
      eval(); chk("ser_run_fire", issue_fire_o, 1); chk("ser_run_busy", serial_busy_o, 0); adv();
      retire_all();

      // x0 never tracked
      for (int i = 0; i < 3; i++) begin
         set_id(0, 0, 0, 0, 0, 1, 0); eval(); adv();
      end
      set_id(0, 1, 0, 1, 4, 1, 0); eval(); chk("x0_read_fire", issue_fire_o, 1); adv();
      retire_all();

      // Same-cycle fire and retire on x7
      set_id(0, 0, 0, 0, 7, 1, 0); eval(); adv();
      wb_on(); eval(); chk("x7_fire_wb", issue_fire_o, 1); adv(); wb_off();
      set_id(7, 1, 0, 0, 8, 0, 0); eval(); chk("x7_still_pending", id_stall_o, 1);
      chk("x7_infl", inflight_o, 1); adv();
      retire_all();

      // Redirect while draining
      set_id(0, 0, 0, 0, 9, 1, 0); eval(); adv();
      set_id(0, 0, 0, 0, 3, 1, 1); eval(); adv();
      eval(); chk("rd_drain_busy", serial_busy_o, 1); adv();
      redirect_i = 1; eval(); chk("rd_flush", flush_o, 1); chk("rd_nofire", issue_fire_o, 0); adv();
      redirect_i = 0; id_valid_i = 0; eval(); chk("rd_flush_off", flush_o, 0);
      chk("rd_run", serial_busy_o, 0); chk("rd_infl_kept", inflight_o, 1); adv();
      set_id(9, 1, 0, 0, 2, 0, 0); eval(); chk("rd_cnt_kept", id_stall_o, 1); adv();
      retire_all();

      // Reset while SERIAL
      set_id(0, 0, 0, 0, 12, 1, 1); eval(); adv();
      id_valid_i = 0; eval(); chk("rs_serial", serial_busy_o, 1); adv();
      rst_i = 1; eval(); adv(); rst_i = 0;
      eval(); chk("rs_busy0", serial_busy_o, 0); chk("rs_infl0", inflight_o, 0); adv();
      set_id(12, 1, 0, 0, 1, 1, 0); eval(); chk("rs_cnt_cleared", issue_fire_o, 1); adv();
      retire_all();

      // Randomized traffic
      need_new = 1;
      for (int c = 0; c < 4000; c++) begin
         rst_i = ($urandom % 500) == 0;
         if (need_new) begin
            set_id($urandom % 6, $urandom % 2, $urandom % 6, $urandom % 2,
                   $urandom % 4, ($urandom % 4) != 0, ($urandom % 10) == 0);
            need_new = 0;
         end
         id_valid_i    = ($urandom % 6) != 0;
         ex_ready_i    = ($urandom % 5) != 0;
         redirect_i    = ($urandom % 15) == 0;
         serial_done_i = ($urandom % 4) == 0;
         if (pipe_q.size() > 0 && ($urandom % 3) == 0) wb_on();
         else begin
            wb_valid_i = 0; wb_rd_i = 5'($urandom % 6); wb_wen_i = $urandom % 2;
         end
         eval();
         if (m_fire || redirect_i || rst_i) need_new = 1;
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
